// File: rtl/compl_mul_pkg.sv
// rtl/compl_mul_pkg.sv - shared types and helpers for the complex multiplier datapath
//
// Holds the multiplier output width, a packed complex sample type and a
// generic saturation helper reused by neighbouring stages.
package compl_mul_pkg;

    // Width of the complex multiplier's signed I/Q products.
    localparam int CM_DATA_W = 19;

    typedef struct packed {
        logic signed [CM_DATA_W-1:0] i;
        logic signed [CM_DATA_W-1:0] q;
    } cplx_t;

    // Clamp a signed value into the range of a signed 'width'-bit number.
    // The result stays 64 bits wide; callers slice the low 'width' bits and
    // detect saturation by comparing the result with the input.
    function automatic logic signed [63:0] sat_fn(input logic signed [63:0] value,
                                                  input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            sat_fn = hi;
        end else if (value < lo) begin
            sat_fn = lo;
        end else begin
            sat_fn = value;
        end
    endfunction

endpackage

// File: rtl/compl_acc_dump_round_sat.sv
// rtl/compl_acc_dump_round_sat.sv - round-half-up, arithmetic right shift and saturate
//
// Purely combinational.
// Ports:
//   value_i  in  IN_W   signed full-precision value
//   result_o out OUT_W  signed rounded, shifted and saturated value
//   sat_o    out 1      result was clamped to the OUT_W range
module round_sat
    import compl_mul_pkg::*;
#(
    parameter int IN_W  = 21,
    parameter int SHIFT = 2,
    parameter int OUT_W = 19
) (
    input  logic signed [IN_W-1:0]  value_i,
    output logic signed [OUT_W-1:0] result_o,
    output logic                    sat_o
);

    // One guard bit so the rounding add can never wrap.
    localparam int EXT_W = IN_W + 1;

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shifted;
    logic signed [63:0]      wide;
    logic signed [63:0]      clamped;

    assign ext = {value_i[IN_W-1], value_i};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
            logic signed [EXT_W-1:0] rounded;
            assign rounded = ext + HALF;
            assign shifted = rounded >>> SHIFT;
        end else begin : g_pass
            assign shifted = ext;
        end
    endgenerate

    assign wide     = {{(64 - EXT_W){shifted[EXT_W-1]}}, shifted};
    assign clamped  = sat_fn(wide, OUT_W);
    assign result_o = clamped[OUT_W-1:0];
    assign sat_o    = (clamped != wide);

endmodule

// File: rtl/compl_acc_dump.sv
// rtl/compl_acc_dump.sv - integrate-and-dump of complex products with rounding and saturation
//
// Sums ACC_N consecutive signed I/Q samples and emits the sum scaled by
// 2^-SHIFT (round half up, saturated to OUT_W) as one complex result.
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   clear_i                   synchronous flush of the partial sum
//   data_i_i, data_q_i        signed input sample, valid_i / ready_o handshake
//   data_i_o, data_q_o, sat_o registered result, valid_o / ready_i handshake
module compl_acc_dump
    import compl_mul_pkg::*;
#(
    parameter int IN_W  = CM_DATA_W,
    parameter int ACC_N = 4,
    parameter int SHIFT = 2,
    parameter int OUT_W = 19
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clear_i,
    input  logic signed [IN_W-1:0]  data_i_i,
    input  logic signed [IN_W-1:0]  data_q_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic signed [OUT_W-1:0] data_i_o,
    output logic signed [OUT_W-1:0] data_q_o,
    output logic                    sat_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int ACC_W = IN_W + $clog2(ACC_N);
    localparam int CNT_W = $clog2(ACC_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_N - 1);

    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt;

    logic signed [ACC_W-1:0] ext_i;
    logic signed [ACC_W-1:0] ext_q;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [OUT_W-1:0] res_i;
    logic signed [OUT_W-1:0] res_q;
    logic                    sat_i;
    logic                    sat_q;

    logic last;
    logic accept;
    logic dump;

    assign last = (cnt == CNT_LAST);

    // Only the dump sample can be blocked: it needs the output register,
    // which is still occupied until downstream takes the pending result.
    assign ready_o = !(last && valid_o && !ready_i);
    assign accept  = valid_i && ready_o;
    assign dump    = accept && last && !clear_i;

    assign ext_i = {{(ACC_W - IN_W){data_i_i[IN_W-1]}}, data_i_i};
    assign ext_q = {{(ACC_W - IN_W){data_q_i[IN_W-1]}}, data_q_i};
    assign sum_i = acc_i + ext_i;
    assign sum_q = acc_q + ext_q;

    round_sat #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat_i (
        .value_i  (sum_i),
        .result_o (res_i),
        .sat_o    (sat_i)
    );

    round_sat #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat_q (
        .value_i  (sum_q),
        .result_o (res_q),
        .sat_o    (sat_q)
    );

    // Accumulator and sample counter; clear wins over an accept.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (clear_i) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (accept) begin
            if (last) begin
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
            end else begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    // Output register; a pending result survives a clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_i_o <= '0;
            data_q_o <= '0;
            sat_o    <= 1'b0;
            valid_o  <= 1'b0;
        end else if (dump) begin
            data_i_o <= res_i;
            data_q_o <= res_q;
            sat_o    <= sat_i | sat_q;
            valid_o  <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_compl_acc_dump.sv
// tb/tb_compl_acc_dump.sv - self-checking bench for compl_acc_dump (SHIFT=2 and SHIFT=1 instances)
module tb_compl_acc_dump;

    localparam int IN_W  = 19;
    localparam int ACC_N = 4;
    localparam int OUT_W = 19;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic valid_i;
    logic ready_i;
    logic signed [IN_W-1:0] din_i;
    logic signed [IN_W-1:0] din_q;

    logic [1:0]              rdy_o;
    logic [1:0]              vld_o;
    logic [1:0]              sat_o;
    logic signed [OUT_W-1:0] out_i [2];
    logic signed [OUT_W-1:0] out_q [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    int     shv   [2] = '{2, 1};
    int     m_cnt [2];
    longint m_acc_i [2];
    longint m_acc_q [2];
    bit     m_val [2];
    longint m_oi  [2];
    longint m_oq  [2];
    bit     m_sat [2];

    always #5 clk = ~clk;

    compl_acc_dump #(.IN_W(IN_W), .ACC_N(ACC_N), .SHIFT(2), .OUT_W(OUT_W)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
        .data_i_i(din_i), .data_q_i(din_q), .valid_i(valid_i), .ready_o(rdy_o[0]),
        .data_i_o(out_i[0]), .data_q_o(out_q[0]), .sat_o(sat_o[0]),
        .valid_o(vld_o[0]), .ready_i(ready_i)
    );

    compl_acc_dump #(.IN_W(IN_W), .ACC_N(ACC_N), .SHIFT(1), .OUT_W(OUT_W)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
        .data_i_i(din_i), .data_q_i(din_q), .valid_i(valid_i), .ready_o(rdy_o[1]),
        .data_i_o(out_i[1]), .data_q_o(out_q[1]), .sat_o(sat_o[1]),
        .valid_o(vld_o[1]), .ready_i(ready_i)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sum / 2^s rounded half up, via floor division.
    function automatic longint round_div(input longint s, input int sh);
        longint d;
        longint t;
        d = longint'(1) << sh;
        t = s + ((sh > 0) ? d / 2 : 0);
        if (t >= 0) return t / d;
        return -((-t + d - 1) / d);
    endfunction

    function automatic longint clamp(input longint r);
        longint hi;
        longint lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_acc_i[k] = 0; m_acc_q[k] = 0;
            m_val[k] = 0; m_oi[k] = 0; m_oq[k] = 0; m_sat[k] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid_o[%0d]", k), 64'(vld_o[k]), 64'(m_val[k]));
            check($sformatf("data_i_o[%0d]", k), 64'(out_i[k]), m_oi[k]);
            check($sformatf("data_q_o[%0d]", k), 64'(out_q[k]), m_oq[k]);
            if (m_val[k]) check($sformatf("sat_o[%0d]", k), 64'(sat_o[k]), 64'(m_sat[k]));
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check ready_o,
    // then advance the model across the rising edge.
    task automatic cyc(input bit v, input longint a, input longint b,
                       input bit clr, input bit rdy);
        bit     exp_rdy [2];
        longint ri;
        longint rq;
        @(negedge clk);
        check_outputs();
        valid_i = v;
        din_i   = IN_W'(a);
        din_q   = IN_W'(b);
        clear   = clr;
        ready_i = rdy;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_rdy[k] = !(m_cnt[k] == ACC_N - 1 && m_val[k] && !rdy);
            check($sformatf("ready_o[%0d]", k), 64'(rdy_o[k]), 64'(exp_rdy[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit dumped = 0;
            if (clr) begin
                m_cnt[k] = 0; m_acc_i[k] = 0; m_acc_q[k] = 0;
            end else if (v && exp_rdy[k]) begin
                m_acc_i[k] += a;
                m_acc_q[k] += b;
                m_cnt[k]++;
                if (m_cnt[k] == ACC_N) begin
                    ri = round_div(m_acc_i[k], shv[k]);
                    rq = round_div(m_acc_q[k], shv[k]);
                    m_oi[k]  = clamp(ri);
                    m_oq[k]  = clamp(rq);
                    m_sat[k] = (m_oi[k] != ri) || (m_oq[k] != rq);
                    m_cnt[k] = 0; m_acc_i[k] = 0; m_acc_q[k] = 0;
                    dumped = 1;
                end
            end
            if (dumped) m_val[k] = 1;
            else if (m_val[k] && rdy) m_val[k] = 0;
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst valid_o[%0d]", k), 64'(vld_o[k]), 64'(0));
            check($sformatf("rst data_i_o[%0d]", k), 64'(out_i[k]), 64'(0));
            check($sformatf("rst data_q_o[%0d]", k), 64'(out_q[k]), 64'(0));
            check($sformatf("rst sat_o[%0d]", k), 64'(sat_o[k]), 64'(0));
            check($sformatf("rst ready_o[%0d]", k), 64'(rdy_o[k]), 64'(1));
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("post-rst valid_o[%0d]", k), 64'(vld_o[k]), 64'(0));
    endtask

    task automatic expect_out(input int k, input longint ei, input longint eq,
                              input bit es, input string tag);
        #1;
        check({tag, " valid"}, 64'(vld_o[k]), 64'(1));
        check({tag, " I"}, 64'(out_i[k]), ei);
        check({tag, " Q"}, 64'(out_q[k]), eq);
        check({tag, " sat"}, 64'(sat_o[k]), 64'(es));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        din_i = '0; din_q = '0;
        model_reset();

        // 1. Reset held from time zero, released mid-cycle.
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("init valid_o[%0d]", k), 64'(vld_o[k]), 64'(0));
            check($sformatf("init data_i_o[%0d]", k), 64'(out_i[k]), 64'(0));
            check($sformatf("init ready_o[%0d]", k), 64'(rdy_o[k]), 64'(1));
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("release valid_o[0]", 64'(vld_o[0]), 64'(0));

        // 2. Basic frame.
        for (int n = 1; n <= 4; n++) cyc(1, n, -n, 0, 1);
        expect_out(0, 3, -2, 0, "basic");
        cyc(0, 0, 0, 0, 1);
        #1 check("basic one-cycle valid", 64'(vld_o[0]), 64'(0));

        // 3. Saturation on the SHIFT=1 instance, then a clean frame.
        for (int n = 0; n < 4; n++) cyc(1, 262143, -262144, 0, 1);
        expect_out(1, 262143, -262144, 1, "sat");
        for (int n = 0; n < 4; n++) cyc(1, 1, 1, 0, 1);
        expect_out(1, 2, 2, 0, "post-sat");
        cyc(0, 0, 0, 0, 1);

        // 4. Backpressure.
        for (int n = 0; n < 4; n++) cyc(1, 1, 1, 0, 0);
        expect_out(0, 1, 1, 0, "bp first");
        for (int n = 0; n < 3; n++) cyc(1, 1, 1, 0, 0);
        #1 check("bp stall ready_o", 64'(rdy_o[0]), 64'(0));
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 1);
        expect_out(0, 1, 1, 0, "bp second");
        cyc(0, 0, 0, 0, 1);

        // 5. Clear discards the partial sum and the concurrent sample.
        cyc(1, 100, 100, 0, 1);
        cyc(1, 100, 100, 0, 1);
        cyc(1, 100, 100, 1, 1);
        for (int n = 0; n < 4; n++) cyc(1, 4, 4, 0, 1);
        expect_out(0, 4, 4, 0, "clear");
        cyc(0, 0, 0, 0, 1);

        // 6. Reset mid-frame, then reset with a pending result.
        cyc(1, 50, 50, 0, 1);
        cyc(1, 50, 50, 0, 1);
        do_reset();
        for (int n = 0; n < 4; n++) cyc(1, 8, -8, 0, 0);
        expect_out(0, 8, -8, 0, "after reset");
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            longint a;
            longint b;
            a = longint'($urandom_range(0, 524287)) - 262144;
            b = longint'($urandom_range(0, 524287)) - 262144;
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? 262143 : -262144;
                b = ($urandom_range(0, 1) == 0) ? 262143 : -262144;
            end
            cyc($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 31) == 0,
                $urandom_range(0, 2) != 0);
        end
        cyc(0, 0, 0, 0, 1);
        @(negedge clk);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
